// File: rtl/corefifo_sync_ctrl.sv
// Single-clock FIFO controller for the COREFIFO USRAM wrapper.
// Owns pointers, occupancy, level flags and read-valid tracking.
module corefifo_sync_ctrl #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 16,
  parameter int AFULL_LEVEL  = 12,
  parameter int AEMPTY_LEVEL = 2,
  parameter int PIPE         = 1,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             WE,
  input  logic [WIDTH-1:0] DATA,
  input  logic             RE,
  output logic [WIDTH-1:0] Q,
  output logic             DVLD,
  output logic             FULL,
  output logic             EMPTY,
  output logic             AFULL,
  output logic             AEMPTY,
  output logic [AW:0]      WRCNT,
  output logic             OVERFLOW,
  output logic             UNDERFLOW,
  output logic [AW-1:0]    RAM_WADDR,
  output logic [WIDTH-1:0] RAM_WDATA,
  output logic             RAM_WEN,
  output logic [AW-1:0]    RAM_RADDR,
  output logic             RAM_REN,
  input  logic [WIDTH-1:0] RAM_RDATA
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_AF   = (AW+1)'(AFULL_LEVEL);
  localparam logic [AW:0] CNT_AE   = (AW+1)'(AEMPTY_LEVEL);

  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, empty_q;
  logic          afull_q, aempty_q;
  logic          ovf_q, udf_q;
  logic [PIPE:0] dvld_q, dvld_d;
  logic          wa, ra;

  assign wa = WE & ~full_q;
  assign ra = RE & ~empty_q;

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, wa};
    rptr_d = rptr_q + {{AW{1'b0}}, ra};
    cnt_d  = cnt_q + {{AW{1'b0}}, wa}
                   - {{AW{1'b0}}, ra};
    // Oldest pop sits in the top bit.
    dvld_d = (dvld_q << 1) | (PIPE+1)'(ra);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      dvld_q   <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == CNT_FULL);
      empty_q  <= (cnt_d == '0);
      afull_q  <= (cnt_d >= CNT_AF);
      aempty_q <= (cnt_d <= CNT_AE);
      ovf_q    <= WE & full_q;
      udf_q    <= RE & empty_q;
      dvld_q   <= dvld_d;
    end
  end

  assign RAM_WEN   = wa;
  assign RAM_WADDR = wptr_q[AW-1:0];
  assign RAM_WDATA = DATA;
  assign RAM_REN   = ra;
  assign RAM_RADDR = rptr_q[AW-1:0];

  assign Q         = RAM_RDATA;
  assign DVLD      = dvld_q[PIPE];
  assign FULL      = full_q;
  assign EMPTY     = empty_q;
  assign AFULL     = afull_q;
  assign AEMPTY    = aempty_q;
  assign WRCNT     = cnt_q;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = udf_q;

  // Pointer distance must always equal occupancy.
  a_ptr_cnt : assert property (
    @(posedge CLOCK) disable iff (RESET)
    (wptr_q - rptr_q) == cnt_q);

endmodule

// File: tb/tb_corefifo_sync_ctrl.sv
// Bench for corefifo_sync_ctrl: queue reference model,
// USRAM behavioural model and a decoupled read-data scoreboard.
module tb_corefifo_sync_ctrl;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic          WE = 1'b0, RE = 1'b0;
  logic [W-1:0]  DATA = '0;
  logic [W-1:0]  Q;
  logic          DVLD, FULL, EMPTY, AFULL, AEMPTY;
  logic [AW:0]   WRCNT;
  logic          OVERFLOW, UNDERFLOW;
  logic [AW-1:0] RAM_WADDR, RAM_RADDR;
  logic [W-1:0]  RAM_WDATA, RAM_RDATA;
  logic          RAM_WEN, RAM_REN;

  corefifo_sync_ctrl #(
    .WIDTH(W), .DEPTH(D), .AFULL_LEVEL(12),
    .AEMPTY_LEVEL(2), .PIPE(1)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .WE(WE), .DATA(DATA), .RE(RE),
    .Q(Q), .DVLD(DVLD),
    .FULL(FULL), .EMPTY(EMPTY),
    .AFULL(AFULL), .AEMPTY(AEMPTY),
    .WRCNT(WRCNT),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW),
    .RAM_WADDR(RAM_WADDR), .RAM_WDATA(RAM_WDATA),
    .RAM_WEN(RAM_WEN), .RAM_RADDR(RAM_RADDR),
    .RAM_REN(RAM_REN), .RAM_RDATA(RAM_RDATA)
  );

  always #5 CLOCK = ~CLOCK;

  // USRAM: registered address plus one output pipeline stage.
  logic [W-1:0] mem [D];
  logic [W-1:0] rd1, rd2;
  always @(posedge CLOCK) begin
    if (RAM_WEN) mem[RAM_WADDR] <= RAM_WDATA;
    if (RAM_REN) rd1 <= mem[RAM_RADDR];
    rd2 <= rd1;
  end
  assign RAM_RDATA = rd2;

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model
  typedef struct {
    logic [W-1:0] d;
    int           due;
  } exp_t;

  logic [W-1:0] fq[$];
  exp_t         exq[$];
  int           m_wp = 0, m_rp = 0;
  bit           m_ovf = 0, m_udf = 0;
  int           cyc_n = 0;

  // Monitor: one cycle counter tick per negedge, pops on DVLD.
  always @(negedge CLOCK) begin
    exp_t e;
    cyc_n++;
    if (DVLD === 1'b1) begin
      if (exq.size() == 0) begin
        chk("dvld_spurious", 1, 0);
      end else begin
        e = exq.pop_front();
        chk("q_data", Q, e.d);
        chk("dvld_latency", cyc_n, e.due);
      end
    end else if (exq.size() != 0 && exq[0].due < cyc_n) begin
      e = exq.pop_front();
      chk("dvld_missing", 0, 1);
    end
  end

  task automatic chk_flags();
    int c;
    c = fq.size();
    chk("wrcnt", WRCNT, c);
    chk("full", FULL, c == D);
    chk("empty", EMPTY, c == 0);
    chk("afull", AFULL, c >= 12);
    chk("aempty", AEMPTY, c <= 2);
    chk("overflow", OVERFLOW, m_ovf);
    chk("underflow", UNDERFLOW, m_udf);
  endtask

  // One clock: drive, check RAM drive, edge, model, check flags.
  task automatic cyc(bit we, bit re, logic [W-1:0] d,
                     bit rst);
    bit full, empty, wa, ra;
    WE = we; RE = re; DATA = d; RESET = rst;
    full  = fq.size() == D;
    empty = fq.size() == 0;
    wa = we && !full;
    ra = re && !empty;
    #1;
    chk("ram_wen", RAM_WEN, wa);
    chk("ram_ren", RAM_REN, ra);
    chk("ram_waddr", RAM_WADDR, m_wp);
    chk("ram_raddr", RAM_RADDR, m_rp);
    chk("ram_wdata", RAM_WDATA, d);
    @(posedge CLOCK);
    if (rst) begin
      fq.delete(); exq.delete();
      m_wp = 0; m_rp = 0; m_ovf = 0; m_udf = 0;
    end else begin
      m_ovf = we && full;
      m_udf = re && empty;
      if (ra) begin
        exq.push_back('{fq.pop_front(), cyc_n + 2});
        m_rp = (m_rp + 1) % D;
      end
      if (wa) begin
        fq.push_back(d);
        m_wp = (m_wp + 1) % D;
      end
    end
    @(negedge CLOCK);
    chk_flags();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    chk("rst_dvld", DVLD, 0);
    chk_flags();

    // Basic push 4 / pop 4
    cyc(1, 0, 32'h11, 0);
    cyc(1, 0, 32'h22, 0);
    cyc(1, 0, 32'h33, 0);
    cyc(1, 0, 32'h44, 0);
    repeat (4) cyc(0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);

    // Fill to full, then overflow attempts
    for (int i = 0; i < D; i++) cyc(1, 0, $urandom, 0);
    cyc(1, 0, 32'hDEAD, 0);
    cyc(1, 0, 32'hBEEF, 0);
    cyc(1, 1, 32'hCAFE, 0);
    while (fq.size() != 0) cyc(0, 1, 0, 0);

    // Underflow
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 32'h77, 0);
    cyc(0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);

    // Simultaneous push/pop at count 5
    for (int i = 0; i < 5; i++) cyc(1, 0, 32'h100 + i, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, 32'h200 + i, 0);
    while (fq.size() != 0) cyc(0, 1, 0, 0);

    // Streaming with shallow occupancy, addresses wrap
    cyc(1, 0, 32'h300, 0);
    cyc(1, 0, 32'h301, 0);
    for (int i = 0; i < 40; i++) begin
      cyc(1, (i % 3) != 2 || fq.size() > 2,
          32'h400 + i, 0);
      if (fq.size() > 2) cyc(0, 1, 0, 0);
    end
    while (fq.size() != 0) cyc(0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);

    // Reset with pops in flight
    cyc(1, 0, 32'h51, 0);
    cyc(1, 0, 32'h52, 0);
    cyc(1, 0, 32'h53, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    chk("rst_mid_dvld", DVLD, 0);
    cyc(1, 0, 32'hA5, 0);
    cyc(0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);

    // Random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      bit we, re, rs;
      we = ($urandom_range(0, 99) < 55);
      re = ($urandom_range(0, 99) < 50);
      rs = ($urandom_range(0, 99) == 0);
      cyc(we, re, $urandom, rs);
    end
    repeat (4) cyc(0, 0, 0, 0);
    chk("scoreboard_drained", exq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
